// File: rtl/setting_editor_multi_pkg.sv
// Shared types for the multi-field operator setting editor: FSM states,
// button bundle, and the action priority used while editing.
package setting_editor_multi_pkg;

    localparam int unsigned F_BOTTLE = 0;
    localparam int unsigned F_PILL   = 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    // Listed in decreasing priority; A_ABORT is the edit-enable-low exit.
    typedef enum logic [2:0] {
        A_NONE      = 3'd0,
        A_CANCEL    = 3'd1,
        A_COMMIT    = 3'd2,
        A_FIELD_CLR = 3'd3,
        A_NEXT      = 3'd4,
        A_INC       = 3'd5,
        A_DEC       = 3'd6,
        A_ABORT     = 3'd7
    } action_t;

    typedef struct packed {
        logic edit_en;
        logic cancel;
        logic commit;
        logic field_clr;
        logic next;
        logic inc;
        logic dec;
    } btn_t;

    // Resolve one edit action per cycle from the detected rises.
    function automatic action_t pick_action(input btn_t rise, input logic edit_low);
        action_t act;
        act = A_NONE;
        if (rise.cancel) begin
            act = A_CANCEL;
        end else if (rise.commit) begin
            act = A_COMMIT;
        end else if (rise.field_clr) begin
            act = A_FIELD_CLR;
        end else if (rise.next) begin
            act = A_NEXT;
        end else if (rise.inc || rise.dec) begin
            // Both rising together cancel out but still consume the cycle.
            if (rise.inc && !rise.dec) begin
                act = A_INC;
            end else if (rise.dec && !rise.inc) begin
                act = A_DEC;
            end
        end else if (edit_low) begin
            act = A_ABORT;
        end
        return act;
    endfunction

endpackage

// File: rtl/setting_editor_multi_if.sv
// Front-panel / run-controller bus of the setting editor.
interface setting_editor_multi_if #(
    parameter int unsigned N_FIELDS = 2,
    parameter int unsigned WIDTH    = 6
);
    localparam int unsigned SEL_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    logic                        in_edit_en;
    logic                        in_next;
    logic                        in_inc;
    logic                        in_dec;
    logic                        in_step_big;
    logic                        in_field_clr;
    logic                        in_commit;
    logic                        in_cancel;
    logic [N_FIELDS-1:0]         out_flash;
    logic [SEL_W-1:0]            out_sel;
    logic                        out_editing;
    logic [N_FIELDS*WIDTH-1:0]   out_work_flat;
    logic [N_FIELDS*WIDTH-1:0]   out_target_flat;
    logic                        out_valid;
    logic                        out_commit_pulse;

    modport master (
        output in_edit_en, in_next, in_inc, in_dec, in_step_big,
               in_field_clr, in_commit, in_cancel,
        input  out_flash, out_sel, out_editing, out_work_flat,
               out_target_flat, out_valid, out_commit_pulse
    );

    modport slave (
        input  in_edit_en, in_next, in_inc, in_dec, in_step_big,
               in_field_clr, in_commit, in_cancel,
        output out_flash, out_sel, out_editing, out_work_flat,
               out_target_flat, out_valid, out_commit_pulse
    );

endinterface

// File: rtl/setting_step_unit.sv
// Next value of one setting after an increment or decrement by step,
// either saturating at 0/MAX_VAL or wrapping modulo MAX_VAL+1.
module setting_step_unit #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MAX_VAL   = 63,
    parameter bit          WRAP_MODE = 1'b0
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] step,
    input  logic             inc,
    output logic [WIDTH-1:0] next_c
);
    localparam int unsigned EW = WIDTH + 1;
    localparam logic [EW-1:0] MAX_E = EW'(MAX_VAL);
    localparam logic [EW-1:0] MOD_E = EW'(MAX_VAL + 1);

    logic [EW-1:0] v_e;
    logic [EW-1:0] s_e;
    logic [EW-1:0] sum_e;

    // One extra bit keeps v+step and v+MOD-step from overflowing.
    always_comb begin
        v_e   = EW'(v);
        s_e   = EW'(step);
        sum_e = v_e + s_e;
        if (inc) begin
            if (sum_e > MAX_E) begin
                next_c = WRAP_MODE ? WIDTH'(sum_e - MOD_E) : WIDTH'(MAX_VAL);
            end else begin
                next_c = WIDTH'(sum_e);
            end
        end else begin
            if (v_e < s_e) begin
                next_c = WRAP_MODE ? WIDTH'(v_e + MOD_E - s_e) : '0;
            end else begin
                next_c = WIDTH'(v_e - s_e);
            end
        end
    end

endmodule

// File: rtl/setting_editor_multi.sv
// Operator setting editor: N_FIELDS settings edited in a working copy and
// applied to the committed copy on commit; cancel or edit-enable drop discards.
module setting_editor_multi
    import setting_editor_multi_pkg::*;
#(
    parameter int unsigned N_FIELDS  = 2,
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MAX_VAL   = 63,
    parameter int unsigned STEP_BIG  = 5,
    parameter bit          WRAP_MODE = 1'b0
) (
    input logic                   in_CLK,
    input logic                   in_CLR,
    setting_editor_multi_if.slave bus
);
    localparam int unsigned SEL_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    typedef logic [WIDTH-1:0] val_t;
    typedef logic [SEL_W-1:0] sel_t;

    state_t  state_q, state_d;
    sel_t    sel_q, sel_d;
    val_t    work_q   [N_FIELDS];
    val_t    work_d   [N_FIELDS];
    val_t    target_q [N_FIELDS];
    val_t    target_d [N_FIELDS];
    logic    pulse_q, pulse_d;
    logic    valid_q, valid_c;
    btn_t    btn_c, btn_q, btn_prev, rise_c;
    logic    step_big_q;
    action_t act_c;
    val_t    step_c, cur_c, stepped_c;
    logic    [N_FIELDS-1:0] flash_c;

    always_comb begin
        btn_c = '{edit_en:   bus.in_edit_en,
                  cancel:    bus.in_cancel,
                  commit:    bus.in_commit,
                  field_clr: bus.in_field_clr,
                  next:      bus.in_next,
                  inc:       bus.in_inc,
                  dec:       bus.in_dec};
    end

    // Button sampling and edge history.
    always_ff @(posedge in_CLK or negedge in_CLR) begin
        if (!in_CLR) begin
            btn_q      <= '0;
            btn_prev   <= '0;
            step_big_q <= 1'b0;
        end else begin
            btn_q      <= btn_c;
            btn_prev   <= btn_q;
            step_big_q <= bus.in_step_big;
        end
    end

    always_comb begin
        rise_c = btn_t'(btn_q & ~btn_prev);
        act_c  = pick_action(rise_c, ~btn_q.edit_en);
        step_c = step_big_q ? WIDTH'(STEP_BIG) : WIDTH'(1);
        cur_c  = work_q[sel_q];
    end

    setting_step_unit #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .WRAP_MODE (WRAP_MODE)
    ) u_step (
        .v      (cur_c),
        .step   (step_c),
        .inc    (act_c == A_INC),
        .next_c (stepped_c)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        work_d   = work_q;
        target_d = target_q;
        pulse_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise_c.edit_en) begin
                    state_d = S_EDIT;
                    sel_d   = '0;
                    work_d  = target_q;
                end
            end
            default: begin
                case (act_c)
                    A_CANCEL, A_ABORT: begin
                        work_d  = target_q;
                        state_d = S_IDLE;
                    end
                    A_COMMIT: begin
                        target_d = work_q;
                        pulse_d  = 1'b1;
                        state_d  = S_IDLE;
                    end
                    A_FIELD_CLR: work_d[sel_q] = '0;
                    A_NEXT: sel_d = (sel_q == SEL_W'(N_FIELDS - 1)) ? '0 : sel_q + SEL_W'(1);
                    A_INC, A_DEC: work_d[sel_q] = stepped_c;
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge in_CLK or negedge in_CLR) begin
        if (!in_CLR) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            for (int k = 0; k < N_FIELDS; k++) begin
                work_q[k]   <= '0;
                target_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pulse_q <= pulse_d;
            valid_q <= valid_c;
            for (int k = 0; k < N_FIELDS; k++) begin
                work_q[k]   <= work_d[k];
                target_q[k] <= target_d[k];
            end
        end
    end

    // Settings are usable only when every committed field is non-zero.
    always_comb begin
        valid_c = 1'b1;
        for (int k = 0; k < N_FIELDS; k++) begin
            if (target_q[k] == '0) begin
                valid_c = 1'b0;
            end
        end
    end

    // Field k blinks on bit N_FIELDS-1-k so field 0 sits at the MSB.
    always_comb begin
        flash_c = '0;
        if (state_q == S_EDIT) begin
            for (int k = 0; k < N_FIELDS; k++) begin
                flash_c[N_FIELDS-1-k] = (sel_q == SEL_W'(k));
            end
        end
    end

    for (genvar g = 0; g < N_FIELDS; g++) begin : g_flat
        assign bus.out_work_flat[g*WIDTH +: WIDTH]   = work_q[g];
        assign bus.out_target_flat[g*WIDTH +: WIDTH] = target_q[g];
    end

    assign bus.out_flash        = flash_c;
    assign bus.out_sel          = sel_q;
    assign bus.out_editing      = (state_q == S_EDIT);
    assign bus.out_valid        = valid_q;
    assign bus.out_commit_pulse = pulse_q;

endmodule

// File: tb/tb_setting_editor_multi.sv
// Directed bench for setting_editor_multi: one saturating and one wrapping
// instance driven by the same front-panel stimulus.
module tb_setting_editor_multi;

    logic clk = 1'b0;
    logic rst_n;
    logic edit_en, nxt, inc, dec, step_big, field_clr, commit, cancel;

    always #5 clk = ~clk;

    setting_editor_multi_if #(.N_FIELDS(2), .WIDTH(6)) sat_if ();
    setting_editor_multi_if #(.N_FIELDS(2), .WIDTH(6)) wrap_if ();

    assign sat_if.in_edit_en    = edit_en;
    assign sat_if.in_next       = nxt;
    assign sat_if.in_inc        = inc;
    assign sat_if.in_dec        = dec;
    assign sat_if.in_step_big   = step_big;
    assign sat_if.in_field_clr  = field_clr;
    assign sat_if.in_commit     = commit;
    assign sat_if.in_cancel     = cancel;
    assign wrap_if.in_edit_en   = edit_en;
    assign wrap_if.in_next      = nxt;
    assign wrap_if.in_inc       = inc;
    assign wrap_if.in_dec       = dec;
    assign wrap_if.in_step_big  = step_big;
    assign wrap_if.in_field_clr = field_clr;
    assign wrap_if.in_commit    = commit;
    assign wrap_if.in_cancel    = cancel;

    setting_editor_multi #(.N_FIELDS(2), .WIDTH(6), .MAX_VAL(63), .STEP_BIG(5), .WRAP_MODE(1'b0))
        dut_sat (.in_CLK(clk), .in_CLR(rst_n), .bus(sat_if));
    setting_editor_multi #(.N_FIELDS(2), .WIDTH(6), .MAX_VAL(63), .STEP_BIG(5), .WRAP_MODE(1'b1))
        dut_wrap (.in_CLK(clk), .in_CLR(rst_n), .bus(wrap_if));

    int errors = 0;
    int checks = 0;
    int pulses_s = 0;
    int pulses_w = 0;

    always @(negedge clk) begin
        if (sat_if.out_commit_pulse === 1'b1)  pulses_s++;
        if (wrap_if.out_commit_pulse === 1'b1) pulses_w++;
    end

    typedef enum {T_ENTER, T_LEAVE, T_INC, T_DEC, T_INCDEC, T_NEXT, T_CLR,
                  T_COMMIT, T_CANCEL, T_COMMIT_CANCEL} op_t;

    typedef struct {
        op_t  op;
        logic big;
        int   rep;
        logic edit;
        int   sel;
        int   w0s, w1s, w0w, w1w;
        int   t0s, t1s, t0w, t1w;
        logic vs, vw;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(op_t op, logic big, int rep, logic edit, int sel,
                                int w0s, int w1s, int w0w, int w1w,
                                int t0s, int t1s, int t0w, int t1w, logic vs, logic vw);
        vec_t v;
        v = '{op, big, rep, edit, sel, w0s, w1s, w0w, w1w, t0s, t1s, t0w, t1w, vs, vw};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input op_t op, input logic big);
        if (op == T_ENTER) begin
            edit_en = 1'b0;
            wait_n(2);
            edit_en = 1'b1;
            wait_n(5);
        end else if (op == T_LEAVE) begin
            edit_en = 1'b0;
            wait_n(5);
        end else begin
            step_big = big;
            case (op)
                T_INC:           inc = 1'b1;
                T_DEC:           dec = 1'b1;
                T_INCDEC:        begin inc = 1'b1; dec = 1'b1; end
                T_NEXT:          nxt = 1'b1;
                T_CLR:           field_clr = 1'b1;
                T_COMMIT:        commit = 1'b1;
                T_CANCEL:        cancel = 1'b1;
                T_COMMIT_CANCEL: begin commit = 1'b1; cancel = 1'b1; end
                default: ;
            endcase
            wait_n(2);
            {inc, dec, nxt, field_clr, commit, cancel} = '0;
            wait_n(5);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [1:0] fl;
        fl = !v.edit ? 2'b00 : ((v.sel == 0) ? 2'b10 : 2'b01);
        check($sformatf("v%0d editing_s", i), 32'(sat_if.out_editing), 32'(v.edit));
        check($sformatf("v%0d editing_w", i), 32'(wrap_if.out_editing), 32'(v.edit));
        check($sformatf("v%0d sel_s", i), 32'(sat_if.out_sel), 32'(v.sel));
        check($sformatf("v%0d flash_s", i), 32'(sat_if.out_flash), 32'(fl));
        check($sformatf("v%0d flash_w", i), 32'(wrap_if.out_flash), 32'(fl));
        check($sformatf("v%0d work0_s", i), 32'(sat_if.out_work_flat[5:0]), 32'(v.w0s));
        check($sformatf("v%0d work1_s", i), 32'(sat_if.out_work_flat[11:6]), 32'(v.w1s));
        check($sformatf("v%0d work0_w", i), 32'(wrap_if.out_work_flat[5:0]), 32'(v.w0w));
        check($sformatf("v%0d work1_w", i), 32'(wrap_if.out_work_flat[11:6]), 32'(v.w1w));
        check($sformatf("v%0d target0_s", i), 32'(sat_if.out_target_flat[5:0]), 32'(v.t0s));
        check($sformatf("v%0d target1_s", i), 32'(sat_if.out_target_flat[11:6]), 32'(v.t1s));
        check($sformatf("v%0d target0_w", i), 32'(wrap_if.out_target_flat[5:0]), 32'(v.t0w));
        check($sformatf("v%0d target1_w", i), 32'(wrap_if.out_target_flat[11:6]), 32'(v.t1w));
        check($sformatf("v%0d valid_s", i), 32'(sat_if.out_valid), 32'(v.vs));
        check($sformatf("v%0d valid_w", i), 32'(wrap_if.out_valid), 32'(v.vw));
    endtask

    int ps, pw;

    initial begin
        //  op               big rep ed sel w0s w1s w0w w1w t0s t1s t0w t1w vs vw
        add(T_ENTER,         0, 1,  1, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0);
        add(T_INC,           0, 3,  1, 0,  3,  0,  3,  0,  0,  0,  0,  0, 0, 0);
        add(T_NEXT,          0, 1,  1, 1,  3,  0,  3,  0,  0,  0,  0,  0, 0, 0);
        add(T_INC,           1, 2,  1, 1,  3, 10,  3, 10,  0,  0,  0,  0, 0, 0);
        add(T_COMMIT,        0, 1,  0, 1,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_ENTER,         0, 1,  1, 0,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_INC,           0, 1,  1, 0,  4, 10,  4, 10,  3, 10,  3, 10, 1, 1);
        add(T_CANCEL,        0, 1,  0, 0,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_ENTER,         0, 1,  1, 0,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_INC,           0, 1,  1, 0,  4, 10,  4, 10,  3, 10,  3, 10, 1, 1);
        add(T_COMMIT_CANCEL, 0, 1,  0, 0,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_ENTER,         0, 1,  1, 0,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_INCDEC,        0, 1,  1, 0,  3, 10,  3, 10,  3, 10,  3, 10, 1, 1);
        add(T_CLR,           0, 1,  1, 0,  0, 10,  0, 10,  3, 10,  3, 10, 1, 1);
        add(T_INC,           1, 12, 1, 0, 60, 10, 60, 10,  3, 10,  3, 10, 1, 1);
        add(T_INC,           0, 1,  1, 0, 61, 10, 61, 10,  3, 10,  3, 10, 1, 1);
        add(T_INC,           1, 1,  1, 0, 63, 10,  2, 10,  3, 10,  3, 10, 1, 1);
        add(T_DEC,           1, 1,  1, 0, 58, 10, 61, 10,  3, 10,  3, 10, 1, 1);
        add(T_CLR,           0, 1,  1, 0,  0, 10,  0, 10,  3, 10,  3, 10, 1, 1);
        add(T_INC,           0, 2,  1, 0,  2, 10,  2, 10,  3, 10,  3, 10, 1, 1);
        add(T_DEC,           1, 1,  1, 0,  0, 10, 61, 10,  3, 10,  3, 10, 1, 1);
        add(T_NEXT,          0, 1,  1, 1,  0, 10, 61, 10,  3, 10,  3, 10, 1, 1);
        add(T_NEXT,          0, 1,  1, 0,  0, 10, 61, 10,  3, 10,  3, 10, 1, 1);
        add(T_DEC,           0, 1,  1, 0,  0, 10, 60, 10,  3, 10,  3, 10, 1, 1);
        add(T_COMMIT,        0, 1,  0, 0,  0, 10, 60, 10,  0, 10, 60, 10, 0, 1);
        add(T_ENTER,         0, 1,  1, 0,  0, 10, 60, 10,  0, 10, 60, 10, 0, 1);
        add(T_INC,           0, 1,  1, 0,  1, 10, 61, 10,  0, 10, 60, 10, 0, 1);
        add(T_LEAVE,         0, 1,  0, 0,  0, 10, 60, 10,  0, 10, 60, 10, 0, 1);

        rst_n = 1'b0;
        {edit_en, nxt, inc, dec, step_big, field_clr, commit, cancel} = '0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(2);

        check("reset editing", 32'(sat_if.out_editing), 32'd0);
        check("reset flash", 32'(sat_if.out_flash), 32'd0);
        check("reset sel", 32'(sat_if.out_sel), 32'd0);
        check("reset work", 32'(sat_if.out_work_flat), 32'd0);
        check("reset target", 32'(sat_if.out_target_flat), 32'd0);
        check("reset valid", 32'(sat_if.out_valid), 32'd0);
        check("reset pulse", 32'(sat_if.out_commit_pulse), 32'd0);
        check("reset wrap target", 32'(wrap_if.out_target_flat), 32'd0);

        ps = pulses_s;
        pw = pulses_w;
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].rep; r++) apply(vecs[i].op, vecs[i].big);
            check_vec(i, vecs[i]);
        end
        // Commits happened at v4 and v24; cancel beat commit at v10.
        check("pulse count table s", 32'(pulses_s - ps), 32'd2);
        check("pulse count table w", 32'(pulses_w - pw), 32'd2);

        // Held increment acts exactly once.
        apply(T_ENTER, 1'b0);
        step_big = 1'b0;
        inc = 1'b1;
        wait_n(10);
        inc = 1'b0;
        wait_n(5);
        check("held inc work0_s", 32'(sat_if.out_work_flat[5:0]), 32'd1);
        check("held inc work0_w", 32'(wrap_if.out_work_flat[5:0]), 32'd61);

        // Single commit pulse and committed values.
        ps = pulses_s;
        pw = pulses_w;
        apply(T_COMMIT, 1'b0);
        check("commit pulses_s", 32'(pulses_s - ps), 32'd1);
        check("commit pulses_w", 32'(pulses_w - pw), 32'd1);
        check("commit target0_s", 32'(sat_if.out_target_flat[5:0]), 32'd1);
        check("commit target0_w", 32'(wrap_if.out_target_flat[5:0]), 32'd61);
        check("commit valid_s", 32'(sat_if.out_valid), 32'd1);

        // Edit-enable drop alongside next: next first, then exit.
        apply(T_ENTER, 1'b0);
        edit_en = 1'b0;
        nxt = 1'b1;
        wait_n(2);
        nxt = 1'b0;
        wait_n(5);
        check("drop+next editing", 32'(sat_if.out_editing), 32'd0);
        check("drop+next sel", 32'(sat_if.out_sel), 32'd1);
        check("drop+next flash", 32'(sat_if.out_flash), 32'd0);

        // Reset in the middle of an edit.
        apply(T_ENTER, 1'b0);
        apply(T_INC, 1'b1);
        check("pre-reset work0_s", 32'(sat_if.out_work_flat[5:0]), 32'd6);
        check("pre-reset work0_w", 32'(wrap_if.out_work_flat[5:0]), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async reset editing", 32'(sat_if.out_editing), 32'd0);
        check("async reset work", 32'(sat_if.out_work_flat), 32'd0);
        check("async reset target", 32'(sat_if.out_target_flat), 32'd0);
        check("async reset valid", 32'(sat_if.out_valid), 32'd0);
        check("async reset sel", 32'(sat_if.out_sel), 32'd0);
        check("async reset flash", 32'(sat_if.out_flash), 32'd0);
        check("async reset wrap work", 32'(wrap_if.out_work_flat), 32'd0);
        edit_en = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(3);
        check("post-reset editing", 32'(sat_if.out_editing), 32'd0);
        apply(T_ENTER, 1'b0);
        check("re-enter editing", 32'(sat_if.out_editing), 32'd1);
        check("re-enter work0_s", 32'(sat_if.out_work_flat[5:0]), 32'd0);
        check("re-enter work0_w", 32'(wrap_if.out_work_flat[5:0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
